// File: rtl/udp_tx_sched.sv
// udp_tx_sched: message-granular round-robin scheduler for the shared UDP TX meta+data path.
// Define UDP_TX_SCHED_STATS_EN to add the per-source saturating message counters (msg_cnts).
module udp_tx_sched #(
  parameter int NUM_SRCS  = 4,
  parameter int BURST_MAX = 4,
  parameter int BURST_W   = $clog2(BURST_MAX + 1),
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRCS-1:0] src_meta_vals,
  output logic [NUM_SRCS-1:0] src_meta_rdys,
  input  logic [NUM_SRCS-1:0] src_data_vals,
  input  logic [NUM_SRCS-1:0] src_data_lasts,
  output logic [NUM_SRCS-1:0] src_data_rdys,
  output logic                dst_meta_val,
  input  logic                dst_meta_rdy,
  output logic                dst_data_val,
  output logic                dst_data_last,
  input  logic                dst_data_rdy,
  output logic [NUM_SRCS-1:0] sel_oh,
  output logic                busy
`ifdef UDP_TX_SCHED_STATS_EN
  ,
  output logic [NUM_SRCS*CNT_W-1:0] msg_cnts
`endif
);

  localparam int IDX_W = $clog2(NUM_SRCS);

  typedef enum logic [1:0] {IDLE, META, DATA} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [BURST_W-1:0]  burst_cnt;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    next_ptr;
  logic [NUM_SRCS-1:0] arb_win;
  logic [NUM_SRCS-1:0] next_win;
  logic                meta_hs;
  logic                last_hs;
  logic                more_burst;

  // First requester at or after ptr, wrapping; later hits in the descending scan win.
  function automatic logic [NUM_SRCS-1:0] arb_pick(input logic [NUM_SRCS-1:0] req,
                                                   input logic [IDX_W-1:0]    ptr);
    logic [NUM_SRCS-1:0] win;
    int                  k;
    win = '0;
    for (int i = NUM_SRCS - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % NUM_SRCS;
      if (((req >> k) & {{(NUM_SRCS-1){1'b0}}, 1'b1}) != '0)
        win = {{(NUM_SRCS-1){1'b0}}, 1'b1} << k;
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] oh_index(input logic [NUM_SRCS-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_SRCS; i++)
      if (oh[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

  assign sel_idx    = oh_index(sel_oh);
  assign next_ptr   = (sel_idx == IDX_W'(NUM_SRCS - 1)) ? '0 : sel_idx + IDX_W'(1);
  assign arb_win    = arb_pick(src_meta_vals, rr_ptr);
  // Scanning from the source after the current one puts the current one last,
  // so it only wins when nobody else is requesting.
  assign next_win   = arb_pick(src_meta_vals, next_ptr);
  assign more_burst = (int'(burst_cnt) < BURST_MAX - 1) && (|(src_meta_vals & sel_oh));

  always_comb begin
    dst_meta_val  = 1'b0;
    src_meta_rdys = '0;
    dst_data_val  = 1'b0;
    dst_data_last = 1'b0;
    src_data_rdys = '0;
    if (!rst && state == META) begin
      dst_meta_val  = |(src_meta_vals & sel_oh);
      src_meta_rdys = dst_meta_rdy ? sel_oh : '0;
    end
    if (!rst && state == DATA) begin
      dst_data_val  = |(src_data_vals & sel_oh);
      dst_data_last = |(src_data_lasts & sel_oh);
      src_data_rdys = dst_data_rdy ? sel_oh : '0;
    end
  end

  assign busy    = !rst && (state != IDLE);
  assign meta_hs = dst_meta_val & dst_meta_rdy;
  assign last_hs = dst_data_val & dst_data_rdy & dst_data_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_oh    <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|src_meta_vals) begin
            sel_oh    <= arb_win;
            burst_cnt <= '0;
            state     <= META;
          end
        end
        META: begin
          if (meta_hs) state <= DATA;
        end
        DATA: begin
          if (last_hs) begin
            if (more_burst) begin
              burst_cnt <= burst_cnt + BURST_W'(1);
              state     <= META;
            end else begin
              rr_ptr <= next_ptr;
              if (|src_meta_vals) begin
                sel_oh    <= next_win;
                burst_cnt <= '0;
                state     <= META;
              end else begin
                sel_oh <= '0;
                state  <= IDLE;
              end
            end
          end
        end
        default: begin
          sel_oh <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef UDP_TX_SCHED_STATS_EN
  for (genvar g = 0; g < NUM_SRCS; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst)
        cnt <= '0;
      else if (last_hs && sel_oh[g] && cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
    end
    assign msg_cnts[g*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule
